// File: rtl/vector_loader.sv
// vector_loader: packs a serial (value, weight) stream into two N-slot operand vectors, runs the calculator and returns its result; optional VECTOR_LOADER_RELU_EN rectifies the result
module vector_loader #(
   parameter int N            = 784,
   parameter int W            = 16,
   parameter int CALC_LATENCY = 11
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_value,
   input  logic [W-1:0]   in_weight,
   input  logic           in_last,
   output logic [N*W-1:0] vec_values,
   output logic [N*W-1:0] vec_weights,
   output logic           calc_en,
   input  logic [15:0]    calc_out,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [15:0]    res_data,
   output logic           busy
);
   localparam int IW = $clog2(N + 1);
   localparam int CW = $clog2(CALC_LATENCY + 1);

   typedef enum logic [1:0] {FILL, COMPUTE, DONE} state_t;

   state_t         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [CW-1:0]  cc_q, cc_d;
   logic [N*W-1:0] vals_q, vals_d;
   logic [N*W-1:0] wts_q, wts_d;
   logic [15:0]    res_q, res_d;
   logic [15:0]    cap;
   logic           accept, close, last_cc;

`ifdef VECTOR_LOADER_RELU_EN
   assign cap = calc_out[15] ? 16'h0000 : calc_out;
`else
   assign cap = calc_out;
`endif

   assign in_ready    = (state_q == FILL) && !reset;
   assign accept      = in_valid && in_ready;
   assign close       = accept && ((idx_q == IW'(N - 1)) || in_last);
   assign last_cc     = cc_q == CW'(CALC_LATENCY);
   assign calc_en     = state_q == COMPUTE;
   assign res_valid   = state_q == DONE;
   assign busy        = state_q != FILL;
   assign res_data    = res_q;
   assign vec_values  = vals_q;
   assign vec_weights = wts_q;

   // next-state: slot writes while filling, latency count while computing, vector clear on result handshake
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cc_d    = cc_q;
      vals_d  = vals_q;
      wts_d   = wts_q;
      res_d   = res_q;
      case (state_q)
         FILL: if (accept) begin
            vals_d[idx_q*W +: W] = in_value;
            wts_d[idx_q*W +: W]  = in_weight;
            idx_d   = close ? '0 : idx_q + IW'(1);
            state_d = close ? COMPUTE : FILL;
         end
         COMPUTE: begin
            cc_d    = last_cc ? '0 : cc_q + CW'(1);
            res_d   = last_cc ? cap : res_q;
            state_d = last_cc ? DONE : COMPUTE;
         end
         DONE: if (res_ready) begin
            vals_d  = '0;
            wts_d   = '0;
            state_d = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   // state registers; reset abandons any frame or result in progress
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FILL;
         idx_q   <= '0;
         cc_q    <= '0;
         vals_q  <= '0;
         wts_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cc_q    <= cc_d;
         vals_q  <= vals_d;
         wts_q   <= wts_d;
         res_q   <= res_d;
      end
   end
endmodule

// File: doc/vector_loader.md
# vector_loader

Front-end writer for the neuron dot-product calculator: accepts a serial stream of (value, weight) pairs over a valid/ready handshake and packs them into the two flattened N×W-bit operand vectors. Once a frame is complete it enables the calculator, holds the operands stable for the calculator's fixed pipeline latency, and captures the 16-bit result. It then presents that result on a valid/ready output port. One loader sits in front of each calculator instance.

## Interface
- N, 784, number of (value, weight) slots per frame
- W, 16, width of each value and weight word
- CALC_LATENCY, 11, calculator register stages from operand capture to a valid result
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  input pair valid
- in_ready  out  1  loader can accept a pair
- in_value  in  W  value word
- in_weight  in  W  weight word
- in_last  in  1  marks the final pair of a short frame
- vec_values  out  N*W  flattened value vector; slot k occupies bits [k*W +: W]
- vec_weights  out  N*W  flattened weight vector; same slot layout as vec_values
- calc_en  out  1  calculator run enable
- calc_out  in  16  calculator result
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts the result
- res_data  out  16  captured result, signed
- busy  out  1  high whenever state is not FILL

## Operation
- The FSM has three states: FILL, COMPUTE and DONE.
- FILL:
  - in_ready = 1 (forced to 0 while reset is high).
  - An accepted pair (in_valid && in_ready) writes slot `idx` of both vectors, then idx increments. idx is clog2(N+1) bits wide.
  - The frame closes when the pair accepted has idx == N-1, or when the accepted pair has in_last = 1. At close, idx clears and the state moves to COMPUTE.
  - Slots not written in a short frame keep the value 0.
  - in_last on the N-th pair is redundant and has no additional effect.
  - in_last with in_valid = 0 is ignored.
- COMPUTE:
  - calc_en = 1, in_ready = 0, and both vectors are frozen.
  - Cycle counter `cc` counts 0..CALC_LATENCY.
  - On the cycle with cc == CALC_LATENCY, calc_out is registered into res_data and the state moves to DONE.
- DONE:
  - res_valid = 1, calc_en = 0, in_ready = 0.
  - res_data stays stable until the handshake.
  - On res_valid && res_ready, all slots of both vectors clear to 0, res_valid drops, and the state returns to FILL.
- Back-pressure: res_ready is don't-care outside DONE. A stalled consumer holds the loader in DONE indefinitely, and no input is accepted meanwhile.
- Reset:
  - State returns to FILL; idx and cc go to 0.
  - vec_values, vec_weights and res_data all go to 0.
  - calc_en = 0, res_valid = 0, busy = 0.
  - Reset in any state abandons the frame or result in progress; no partial result is ever emitted.
- No arithmetic is done on operand words; they pass through bit-exact.

## Timing
- A pair accepted in cycle t is visible on the vectors in cycle t+1.
- If the frame closes on the pair accepted in cycle t:
  - calc_en is high in cycles t+1 through t+1+CALC_LATENCY, i.e. CALC_LATENCY+1 cycles.
  - res_data is captured at the end of cycle t+1+CALC_LATENCY.
  - res_valid first goes high in cycle t+2+CALC_LATENCY.
- A result handshake in cycle u gives in_ready = 1 and cleared vectors in cycle u+1.
- Minimum frame period is N + CALC_LATENCY + 2 cycles with res_ready held high.
- in_ready is combinational from the state and reset only; it never depends on in_valid.

## Configuration
- VECTOR_LOADER_RELU_EN:
  - Defined: the captured result is rectified. If calc_out[15] = 1, res_data is 16'h0000; otherwise res_data = calc_out.
  - Undefined: res_data = calc_out unmodified.
- Timing is identical in both builds.

## Test plan
- Full frame with pair k = (value k, weight 16'hFFFF−k): slot 0 reads 16'h0000/16'hFFFF and slot 783 reads 16'h030F/16'hFCF0. in_ready is 0 for the cycle after the 784th accept.
- Short frame of 3 pairs (0x0100, 0x0200), (0x0300, 0x0400), (0x0500, 0x0600) with in_last on the third: slots 0–2 hold those words and slots 3–783 are 0. calc_en rises on the next cycle.
- Calculator stub drives calc_out = 16'h1234 while calc_en is high and 0 otherwise: exactly 12 cycles of calc_en, res_data = 16'h1234, and res_valid appears 13 cycles after the closing accept.
- Hold res_ready = 0 for 20 cycles in DONE: res_valid and res_data stay stable, in_ready stays 0, and in_valid is ignored. Raising res_ready gives vectors all 0 and in_ready = 1 on the next cycle.
- Stub drives calc_out = 16'hFF00: res_data = 16'h0000 with VECTOR_LOADER_RELU_EN defined, 16'hFF00 without.
- Assert reset mid-COMPUTE (cc = 5): the next cycle shows FILL, calc_en = 0, res_valid = 0, zeroed vectors, and no result is ever emitted for that frame.
